// File: rtl/hilo_mul_sequencer.sv
// HI/LO multiply sequencer: 32x32 radix-2 shift-add multiplier with optional
// accumulate into the 64-bit HI/LO pair, plus direct HI/LO writes.
module hilo_mul_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for start; mthi/mtlo accepted here only
    // CALC  | 32 shift-add steps on operand magnitudes
    // SIGN  | apply two's complement when result sign is negative
    // WRITE | load or accumulate product into HI/LO, pulse done
    typedef enum logic [1:0] {IDLE, CALC, SIGN, WRITE} state_t;

    state_t      state_q;
    logic        acc_q;
    logic        neg_q;
    logic [31:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] prod_q;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic        signed_op;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [63:0] prod_add_d;
    logic [63:0] hilo_sum_d;

    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign signed_op  = ~op[0];
    assign rs_mag     = (signed_op && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
    assign rt_mag     = (signed_op && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
    assign prod_add_d = mplier_q[cnt_q] ? ({32'd0, mcand_q} << cnt_q) : 64'd0;
    assign hilo_sum_d = {hi_q, lo_q} + prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            prod_q   <= 64'd0;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mthi) hi_q <= rs_val;
                    if (mtlo) lo_q <= rs_val;
                    if (start) begin
                        acc_q    <= op[1];
                        neg_q    <= signed_op & (rs_val[31] ^ rt_val[31]);
                        mcand_q  <= rs_mag;
                        mplier_q <= rt_mag;
                        prod_q   <= 64'd0;
                        cnt_q    <= 5'd0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    prod_q <= prod_q + prod_add_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= SIGN;
                end
                SIGN: begin
                    if (neg_q) prod_q <= ~prod_q + 64'd1;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (acc_q) {hi_q, lo_q} <= hilo_sum_d;
                    else       {hi_q, lo_q} <= prod_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// Directed self-checking bench for hilo_mul_sequencer; inputs change and
// outputs are sampled on the falling edge.
module tb_hilo_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MADD  = 2'b10;
    localparam logic [1:0] OP_MADDU = 2'b11;

    hilo_mul_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_hilo(input logic wr_hi, input logic wr_lo, input logic [31:0] val);
        mthi   = wr_hi;
        mtlo   = wr_lo;
        rs_val = val;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
    endtask

    // Launches one operation and waits for done with a cycle budget.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int lat;
        int busy_cnt;
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd34);
        check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int done_cnt;
        int lat;
        rst    = 1'b1;
        start  = 1'b0;
        op     = OP_MULT;
        rs_val = 32'd0;
        rt_val = 32'd0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'd0, busy, done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("multu_ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("mult_pos_neg", OP_MULT, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2);

        write_hilo(1'b1, 1'b0, 32'h0);
        write_hilo(1'b0, 1'b1, 32'hFFFF_FFFF);
        check("mt_write", {hi, lo}, {32'h0, 32'hFFFF_FFFF});
        run_op("maddu_carry", OP_MADDU, 32'd1, 32'd1, 32'h0000_0001, 32'h0000_0000);

        write_hilo(1'b1, 1'b0, 32'h0);
        write_hilo(1'b0, 1'b1, 32'd10);
        run_op("madd_neg", OP_MADD, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // start and mthi while busy are ignored; operand changes have no effect
        op     = OP_MULTU;
        rs_val = 32'd7;
        rt_val = 32'd9;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_cnt = 0;
        lat      = 0;
        while (!done && lat < 60) begin
            start  = (lat == 5 || lat == 20);
            mthi   = (lat == 10);
            op     = OP_MADD;
            rs_val = 32'hDEAD_BEEF;
            rt_val = 32'hFFFF;
            if (lat == 12) check("busy_mthi_ignored", {32'd0, hi}, 64'hFFFF_FFFF);
            @(negedge clk);
            lat++;
        end
        check("busy_latency", 64'(lat), 64'd34);
        check("busy_result", {hi, lo}, {32'd0, 32'd63});
        // back-to-back start in the done cycle
        mthi   = 1'b0;
        op     = OP_MULTU;
        rs_val = 32'd4;
        rt_val = 32'd5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 50; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("b2b_done_count", 64'(done_cnt), 64'd1);
        check("b2b_result", {hi, lo}, {32'd0, 32'd20});

        // mthi together with start: HI written at acceptance, then accumulated onto
        mthi = 1'b1;
        run_op("mthi_with_start", OP_MADDU, 32'd5, 32'd2, 32'd5, 32'd30);
        mthi = 1'b0;

        write_hilo(1'b1, 1'b1, 32'h1234_5678);
        check("mt_both", {hi, lo}, {32'h1234_5678, 32'h1234_5678});

        // reset mid-operation
        op     = OP_MULT;
        rs_val = 32'hFFFF_FFF9;
        rt_val = 32'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {hi, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        run_op("post_reset", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
